// File: rtl/op_sequencer.sv
// op_sequencer: buffers {op,a,b} commands in a FIFO and issues them one at a
// time to an external datapath. The result and comparator flags are captured
// after DP_LATENCY cycles and held on a valid/ready response port.
// Commands complete in acceptance order, with at most one in flight.
//
// Ports:
//   clk_in, rst_in             clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op/cmd_a/cmd_b payload
//   dp_a, dp_b, dp_op_sel      registered operands/opcode to the datapath
//   dp_result, dp_lt/gt/eq     datapath result and comparator flags
//   rsp_valid/rsp_ready        response handshake; rsp_data/rsp_flags/rsp_err
//   busy                       FSM not idle or FIFO not empty
module op_sequencer #(
    parameter int DATAWIDTH  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DP_LATENCY = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [4:0]           cmd_op,
    input  logic [DATAWIDTH-1:0] cmd_a,
    input  logic [DATAWIDTH-1:0] cmd_b,
    output logic [DATAWIDTH-1:0] dp_a,
    output logic [DATAWIDTH-1:0] dp_b,
    output logic [4:0]           dp_op_sel,
    input  logic [DATAWIDTH-1:0] dp_result,
    input  logic                 dp_lt,
    input  logic                 dp_gt,
    input  logic                 dp_eq,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic [2:0]           rsp_flags,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WC_W    = $clog2(DP_LATENCY + 1);
    localparam int ENTRY_W = 5 + 2 * DATAWIDTH;
    localparam logic [4:0] OP_MAX = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, empty, push, pop;

    logic [ENTRY_W-1:0]   head;
    logic [4:0]           head_op;
    logic [DATAWIDTH-1:0] head_a, head_b;

    logic [WC_W-1:0] wait_cnt;
    logic            issue, err_rsp, capture, rsp_done;

    // ------------------------------------------------------------------
    // Command FIFO. Full is taken from the pre-edge count, so a pop on the
    // same edge never lets a push into a full buffer.
    // ------------------------------------------------------------------
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = rst_in & ~full;
    assign push      = cmd_valid & cmd_ready;

    assign head    = fifo_mem[rd_ptr];
    assign head_op = head[ENTRY_W-1 -: 5];
    assign head_a  = head[2*DATAWIDTH-1 -: DATAWIDTH];
    assign head_b  = head[DATAWIDTH-1:0];

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-2 depth: pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        err_rsp    = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_op > OP_MAX) begin
                        err_rsp    = 1'b1;
                        state_next = RESP;
                    end else begin
                        issue      = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == WC_W'(1)) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath drive and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            dp_a      <= '0;
            dp_b      <= '0;
            dp_op_sel <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (issue) begin
                dp_a      <= head_a;
                dp_b      <= head_b;
                dp_op_sel <= head_op;
                wait_cnt  <= WC_W'(DP_LATENCY);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - WC_W'(1);
            end

            if (capture) begin
                rsp_data  <= dp_result;
                rsp_flags <= {dp_lt, dp_gt, dp_eq};
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
            end else if (err_rsp) begin
                rsp_data  <= '0;
                rsp_flags <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer. Main instance uses DP_LATENCY=1 with an
// a+b datapath model; a second instance uses DP_LATENCY=3 with a datapath
// whose result follows a free-running cycle counter, so the capture cycle
// is visible in the captured value.
module tb_op_sequencer;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk_in) cyc <= cyc + 32'd1;

    logic       rst_in;
    logic       cmd_valid, cmd_ready;
    logic [4:0] cmd_op;
    logic [1:0] cmd_a, cmd_b;
    logic [1:0] dp_a, dp_b, dp_result;
    logic [4:0] dp_op_sel;
    logic       dp_lt, dp_gt, dp_eq;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic [1:0] rsp_data;
    logic [2:0] rsp_flags;

    assign dp_result = dp_a + dp_b;
    assign dp_lt     = (dp_a < dp_b);
    assign dp_gt     = (dp_a > dp_b);
    assign dp_eq     = (dp_a == dp_b);

    op_sequencer #(.DATAWIDTH(2), .FIFO_DEPTH(4), .DP_LATENCY(1)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_op_sel(dp_op_sel),
        .dp_result(dp_result), .dp_lt(dp_lt), .dp_gt(dp_gt), .dp_eq(dp_eq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy)
    );

    logic       l3_valid, l3_ready;
    logic [4:0] l3_op, l3_dp_op_sel;
    logic [1:0] l3_a, l3_b, l3_dp_a, l3_dp_b, l3_dp_result, l3_rsp_data;
    logic       l3_rsp_valid, l3_rsp_err, l3_busy;
    logic [2:0] l3_rsp_flags;

    assign l3_dp_result = cyc[1:0];

    op_sequencer #(.DATAWIDTH(2), .FIFO_DEPTH(4), .DP_LATENCY(3)) u_dut_l3 (
        .clk_in(clk_in), .rst_in(rst_in),
        .cmd_valid(l3_valid), .cmd_ready(l3_ready),
        .cmd_op(l3_op), .cmd_a(l3_a), .cmd_b(l3_b),
        .dp_a(l3_dp_a), .dp_b(l3_dp_b), .dp_op_sel(l3_dp_op_sel),
        .dp_result(l3_dp_result), .dp_lt(1'b0), .dp_gt(1'b0), .dp_eq(1'b0),
        .rsp_valid(l3_rsp_valid), .rsp_ready(1'b1),
        .rsp_data(l3_rsp_data), .rsp_flags(l3_rsp_flags), .rsp_err(l3_rsp_err),
        .busy(l3_busy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_cmd(input logic [4:0] op, input logic [1:0] a, input logic [1:0] b);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b1; l3_valid = 1'b0; l3_op = '0; l3_a = '0; l3_b = '0;
        step(); step();
        total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (dp_a !== 2'd0 || dp_b !== 2'd0 || dp_op_sel !== 5'd0)
            $display("FAIL reset_dp: got a=%0d b=%0d op=%0d want 0 0 0", dp_a, dp_b, dp_op_sel); else pass_cnt++;
        total_cnt++; if (rsp_data !== 2'd0 || rsp_flags !== 3'd0 || rsp_err !== 1'b0)
            $display("FAIL reset_rsp: got d=%0d f=%b e=%b want 0 000 0", rsp_data, rsp_flags, rsp_err); else pass_cnt++;
        rst_in = 1'b1;
        #1;
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready); else pass_cnt++;
    endtask

    task automatic test_basic();
        rsp_ready = 1'b1;
        send_cmd(5'd0, 2'd1, 2'd2);
        step();
        total_cnt++; if (dp_op_sel !== 5'd0 || dp_a !== 2'd1 || dp_b !== 2'd2)
            $display("FAIL basic_dp: got op=%0d a=%0d b=%0d want 0 1 2", dp_op_sel, dp_a, dp_b); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL basic_early_rsp: got %b want 0", rsp_valid); else pass_cnt++;
        step();
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 2'd3 || rsp_err !== 1'b0)
            $display("FAIL basic_rsp: got v=%b d=%0d e=%b want 1 3 0", rsp_valid, rsp_data, rsp_err); else pass_cnt++;
        total_cnt++; if (rsp_flags !== 3'b100) $display("FAIL basic_flags: got %b want 100", rsp_flags); else pass_cnt++;
        step();
        total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_done: got v=%b busy=%b want 0 0", rsp_valid, busy); else pass_cnt++;
    endtask

    task automatic test_full();
        logic [1:0] a_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
        logic [1:0] b_tab [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        logic [1:0] exp_d [5] = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd2};
        logic [1:0] got [$];
        logic [1:0] v;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; cmd_op = 5'd0; cmd_a = a_tab[k]; cmd_b = b_tab[k];
            total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL full_push%0d_ready: got %b want 1", k, cmd_ready); else pass_cnt++;
            step();
        end
        cmd_a = 2'd3; cmd_b = 2'd3;
        total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL full_ready_low: got %b want 0", cmd_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 2'd2 || rsp_flags !== 3'b001)
            $display("FAIL full_first_rsp: got v=%b d=%0d f=%b want 1 2 001", rsp_valid, rsp_data, rsp_flags); else pass_cnt++;
        step(); step();
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 2'd2 || cmd_ready !== 1'b0)
            $display("FAIL full_hold: got v=%b d=%0d rdy=%b want 1 2 0", rsp_valid, rsp_data, cmd_ready); else pass_cnt++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total_cnt++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL full_after_ack: got v=%b rdy=%b want 0 0", rsp_valid, cmd_ready); else pass_cnt++;
        step();
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL full_after_pop_ready: got %b want 1", cmd_ready); else pass_cnt++;
        step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && got.size() < 5; i++) begin
            if (rsp_valid === 1'b1) got.push_back(rsp_data);
            step();
        end
        total_cnt++; if (got.size() != 5) $display("FAIL full_drain_count: got %0d want 5", got.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            v = (i < got.size()) ? got[i] : 2'bxx;
            total_cnt++; if (v !== exp_d[i]) $display("FAIL full_drain%0d: got %0d want %0d", i, v, exp_d[i]); else pass_cnt++;
        end
        total_cnt++; if (busy !== 1'b0) $display("FAIL full_busy_end: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_invalid();
        rsp_ready = 1'b1;
        send_cmd(5'd3, 2'd2, 2'd1);
        step();
        total_cnt++; if (dp_op_sel !== 5'd3) $display("FAIL inv_prior_op: got %0d want 3", dp_op_sel); else pass_cnt++;
        step();
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_flags !== 3'b010)
            $display("FAIL inv_prior_rsp: got v=%b e=%b f=%b want 1 0 010", rsp_valid, rsp_err, rsp_flags); else pass_cnt++;
        step();
        send_cmd(5'd15, 2'd3, 2'd3);
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL inv_early: got %b want 0", rsp_valid); else pass_cnt++;
        step();
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 2'd0 || rsp_flags !== 3'd0)
            $display("FAIL inv_rsp: got v=%b e=%b d=%0d f=%b want 1 1 0 000", rsp_valid, rsp_err, rsp_data, rsp_flags); else pass_cnt++;
        total_cnt++; if (dp_op_sel !== 5'd3 || dp_a !== 2'd2 || dp_b !== 2'd1)
            $display("FAIL inv_dp_held: got op=%0d a=%0d b=%0d want 3 2 1", dp_op_sel, dp_a, dp_b); else pass_cnt++;
        step();
        total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL inv_done: got v=%b busy=%b want 0 0", rsp_valid, busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] a_tab [3] = '{2'd1, 2'd2, 2'd1};
        logic [1:0] b_tab [3] = '{2'd2, 2'd0, 2'd0};
        logic [1:0] exp_d [3] = '{2'd3, 2'd2, 2'd1};
        logic [1:0]  got_d [$];
        logic [31:0] got_t [$];
        logic [31:0] acc_t;
        rsp_ready = 1'b1;
        acc_t = '0;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_op = 5'd0; cmd_a = a_tab[k]; cmd_b = b_tab[k];
            step();
            if (k == 0) acc_t = cyc;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 30 && got_d.size() < 3; i++) begin
            if (rsp_valid === 1'b1) begin
                got_d.push_back(rsp_data);
                got_t.push_back(cyc);
            end
            step();
        end
        total_cnt++;
        if (got_d.size() != 3) begin
            $display("FAIL b2b_count: got %0d want 3", got_d.size());
        end else begin
            pass_cnt++;
            total_cnt++; if (got_t[0] - acc_t != 32'd2) $display("FAIL b2b_latency: got %0d want 2", got_t[0] - acc_t); else pass_cnt++;
            for (int i = 0; i < 3; i++) begin
                total_cnt++; if (got_d[i] !== exp_d[i]) $display("FAIL b2b_data%0d: got %0d want %0d", i, got_d[i], exp_d[i]); else pass_cnt++;
            end
            for (int i = 1; i < 3; i++) begin
                total_cnt++; if (got_t[i] - got_t[i-1] != 32'd3)
                    $display("FAIL b2b_spacing%0d: got %0d want 3", i, got_t[i] - got_t[i-1]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] a_tab [4] = '{2'd1, 2'd1, 2'd2, 2'd3};
        logic [1:0] b_tab [4] = '{2'd1, 2'd2, 2'd2, 2'd0};
        int n;
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_op = 5'd0; cmd_a = a_tab[k]; cmd_b = b_tab[k];
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
        total_cnt++; if (busy !== 1'b1 || dp_a !== 2'd1 || dp_b !== 2'd2)
            $display("FAIL rmid_pre: got busy=%b a=%0d b=%0d want 1 1 2", busy, dp_a, dp_b); else pass_cnt++;
        rst_in = 1'b0;
        #1;
        total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL rmid_ready_in_reset: got %b want 0", cmd_ready); else pass_cnt++;
        step();
        rst_in = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL rmid_post: got busy=%b v=%b rdy=%b want 0 0 1", busy, rsp_valid, cmd_ready); else pass_cnt++;
        total_cnt++; if (dp_a !== 2'd0 || dp_op_sel !== 5'd0)
            $display("FAIL rmid_dp_cleared: got a=%0d op=%0d want 0 0", dp_a, dp_op_sel); else pass_cnt++;
        n = 0;
        repeat (10) begin
            if (rsp_valid !== 1'b0) n++;
            step();
        end
        total_cnt++; if (n != 0 || busy !== 1'b0)
            $display("FAIL rmid_no_rsp: got %0d responses busy=%b want 0 0", n, busy); else pass_cnt++;
    endtask

    task automatic test_latency3();
        logic [31:0] c0, e;
        logic [1:0]  d;
        int found;
        total_cnt++; if (l3_ready !== 1'b1) $display("FAIL l3_ready: got %b want 1", l3_ready); else pass_cnt++;
        l3_valid = 1'b1; l3_op = 5'd0; l3_a = 2'd1; l3_b = 2'd2;
        step();
        c0 = cyc;
        l3_valid = 1'b0;
        found = 0;
        d = '0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (found == 0 && l3_rsp_valid === 1'b1) begin
                found = k;
                d = l3_rsp_data;
            end
        end
        e = c0 + 32'd3;
        total_cnt++; if (found != 4) $display("FAIL l3_latency: got %0d edges want 4", found); else pass_cnt++;
        total_cnt++; if (d !== e[1:0]) $display("FAIL l3_capture: got %0d want %0d", d, e[1:0]); else pass_cnt++;
        total_cnt++; if (l3_rsp_err !== 1'b0 || l3_rsp_flags !== 3'd0 || l3_busy !== 1'b0)
            $display("FAIL l3_end: got e=%b f=%b busy=%b want 0 000 0", l3_rsp_err, l3_rsp_flags, l3_busy); else pass_cnt++;
        total_cnt++; if (l3_dp_a !== 2'd1 || l3_dp_b !== 2'd2 || l3_dp_op_sel !== 5'd0)
            $display("FAIL l3_dp: got a=%0d b=%0d op=%0d want 1 2 0", l3_dp_a, l3_dp_b, l3_dp_op_sel); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_latency3();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter DATAWIDTH, default 2: operand/result width; SHALL match the downstream datapath.
REQ-002 Parameter FIFO_DEPTH, default 4: command buffer entries, power of 2, at least 2.
REQ-003 Parameter DP_LATENCY, default 1: cycles from dp_* outputs changing to dp_result being valid, at least 1.
REQ-004 clk_in  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_in  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd_ready  out  1  command buffer can accept.
REQ-008 cmd_op  in  5  opcode; 0..10 valid (ADD, DEC, DIV, INC, MOD, MUL, MUX, REG, SHL, SHR, SUB).
REQ-009 cmd_a, cmd_b  in  DATAWIDTH  operands.
REQ-010 dp_a, dp_b  out  DATAWIDTH  registered operands to the datapath a/b.
REQ-011 dp_op_sel  out  5  registered opcode to the datapath op_sel.
REQ-012 dp_result  in  DATAWIDTH  datapath out.
REQ-013 dp_lt, dp_gt, dp_eq  in  1 each  datapath comparator flags.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  consumer accepts the response.
REQ-016 rsp_data  out  DATAWIDTH  captured result.
REQ-017 rsp_flags  out  3  captured {lt,gt,eq}.
REQ-018 rsp_err  out  1  opcode was invalid (>10).
REQ-019 busy  out  1  high when the FSM is not in IDLE or the FIFO is not empty.

Function
REQ-020 A command SHALL be accepted on an edge where cmd_valid and cmd_ready are both high, and pushed into the FIFO as {op,a,b}.
REQ-021 cmd_ready SHALL be 0 when the FIFO is full; this SHALL be derived from the pre-edge count, so no push occurs when full even if a pop happens on the same edge.
REQ-022 When the FIFO is not full, a push and a pop on the same edge SHALL leave the count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-024 IDLE, FIFO non-empty, head op 0..10: on the edge, pop, load dp_a/dp_b/dp_op_sel from the head, load wait_cnt=DP_LATENCY, go to WAIT.
REQ-025 IDLE, FIFO non-empty, head op >10: on the edge, pop, leave the dp_* outputs unchanged, set rsp_data=0, rsp_flags=0, rsp_err=1, rsp_valid=1, go to RESP.
REQ-026 IDLE, FIFO empty: remain in IDLE with the dp_* outputs held.
REQ-027 WAIT: decrement wait_cnt on each edge; on the edge where wait_cnt==1, capture rsp_data=dp_result, rsp_flags={dp_lt,dp_gt,dp_eq}, rsp_err=0, rsp_valid=1, and go to RESP.
REQ-028 RESP: hold rsp_* stable while rsp_ready is low; on the edge with rsp_ready high, clear rsp_valid and go to IDLE.
REQ-029 Latency with DP_LATENCY=1, FIFO empty, FSM idle, command accepted at edge T: dp_* update at T+1, rsp_valid rises at T+2.
REQ-030 The minimum issue interval SHALL be DP_LATENCY+2 cycles per command (1 for IDLE, DP_LATENCY for WAIT, 1 for RESP with rsp_ready held high).
REQ-031 Commands SHALL complete strictly in acceptance order; there is one command in flight maximum.
REQ-032 The FIFO SHALL continue accepting commands during WAIT and RESP.

Reset
REQ-033 Reset is sampled on an edge with rst_in=0; it SHALL force state=IDLE, FIFO count=0, both pointers=0, wait_cnt=0, dp_a=dp_b=0, dp_op_sel=0, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0.
REQ-034 cmd_ready SHALL be 0 while rst_in=0, and SHALL be 1 in the first cycle after rst_in returns high.
REQ-035 Reset mid-operation (WAIT or RESP, FIFO non-empty) SHALL discard all buffered and in-flight commands with no response emitted.

Verification
REQ-036 DATAWIDTH=2, DP_LATENCY=1: send op=0, a=1, b=2 at edge T with the datapath model returning 3 -> dp_op_sel=0, dp_a=1, dp_b=2 after T+1; rsp_valid=1, rsp_data=3, rsp_err=0 after T+2.
REQ-037 With rsp_ready held 0, push 4 commands, then a 5th -> cmd_ready=0 once the count reaches 4 while the first response is held; the 5th is accepted only after a pop.
REQ-038 Send op=15 -> rsp_valid one cycle after leaving IDLE, rsp_data=0, rsp_err=1, dp_op_sel unchanged from its prior value.
REQ-039 Send 3 commands back-to-back with rsp_ready=1 and the datapath returning a+b -> 3 responses in order, each spaced exactly 3 cycles apart.
REQ-040 Assert rst_in=0 for 1 cycle during WAIT with 2 commands queued -> after release, busy=0 and rsp_valid=0, and no response appears in the following 10 cycles.
REQ-041 DP_LATENCY=3: a single command -> rsp_valid rises 4 edges after the acceptance edge, capturing dp_result from the final WAIT cycle.
